uart_dec_parser: RTL and testbench
==================================

// Module: uart_dec_parser
// PURPOSE
//   Decodes ASCII decimal text from the UART receiver into a binary value. It is the
//   decimal-text-to-binary counterpart of the binary-to-BCD display path.
//   It sits between uart_rx (rx_data/received) and any register or display logic that takes an 8-bit value.
//   A line of decimal digits ended by CR or LF produces one value pulse.
//   Malformed or out-of-range lines produce one error pulse and no value.
// PARAMETERS
//   WIDTH       8    width of the parsed value and the value output
//   MAX_VALUE   255  largest accepted value; must be <= 2**WIDTH-1
//   MAX_DIGITS  3    largest digit count per line; leading zeros count as digits
// PORTS
//   clk          in   1      system clock; all logic is on the rising edge
//   rst          in   1      asynchronous, active-high reset
//   rx_data      in   8      received byte; sampled only when received=1
//   received     in   1      single-cycle strobe; may be high on consecutive cycles
//   value        out  WIDTH  last successfully parsed value; holds until the next success
//   value_valid  out  1      one-cycle pulse when value updates
//   err          out  1      one-cycle pulse when a line is rejected
//   err_code     out  2      reason for err; held until the next err (1=overflow, 2=bad char)
//   busy         out  1      high while a line is partially parsed (state != IDLE)
// BEHAVIOUR
//   Reset: state=IDLE, acc=0, digit count=0, value=0, value_valid=0, err=0, err_code=0, busy=0.
//   Asserting rst mid-line discards the partial line and produces no pulse.
//   Bytes are consumed only on cycles where received=1; all other cycles hold state.
//   Latency: value_valid and err rise on the clock edge that consumes the terminating or
//     offending byte, and are high for exactly one cycle.
//   Classes: digit 0x30-0x39; terminator 0x0D or 0x0A; space 0x20; any other byte is "other".
//   Accumulator: acc and the product are WIDTH+4 bits wide.
//     Each digit computes next = acc*10 + (byte-0x30) using shift-and-add ((acc<<3)+(acc<<1)).
//     No multiplier primitive is required.
//   State IDLE (no digits yet):
//     digit      -> acc=digit, count=1, go ACCUM
//     terminator -> ignored; CRLF and blank lines give no pulse
//     space      -> ignored
//     other      -> err=1, err_code=2, go DISCARD
//   State ACCUM:
//     digit, count==MAX_DIGITS  -> err=1, err_code=1, go DISCARD
//     digit, next>MAX_VALUE     -> err=1, err_code=1, go DISCARD
//     digit, otherwise          -> acc=next, count+1
//     terminator -> value=acc[WIDTH-1:0], value_valid=1, acc=0, count=0, go IDLE
//     space or other -> err=1, err_code=2, go DISCARD
//   State DISCARD:
//     terminator -> go IDLE, acc=0, count=0, no pulse
//     all other bytes -> ignored; no further err pulses for the same line
//   value_valid and err never assert in the same cycle.
//   value changes only on a value_valid cycle.
//   Boundary values: "255" is accepted; "256" gives overflow on the third digit.
//     "0" is accepted (value=0). "000" is accepted. "0000" gives overflow (digit count).
//   Back-to-back: received on every cycle (e.g. '7' then LF on the next cycle) must give
//     value_valid on the LF cycle.
// TESTING
//   rx "1","2","3",CR -> value_valid one cycle after the CR strobe, value=123, err never asserts.
//   rx "255",LF then "256",LF -> first line: value=255 pulse.
//     Second line: err pulse with err_code=1 on the '6' strobe; LF gives no pulse; value stays 255.
//   rx "4","x","2",CR -> err pulse err_code=2 on 'x'; no value_valid; busy=0 after CR.
//   rx CR,LF,CR,LF then "0",CR,LF -> exactly one value_valid (value=0).
//     busy is high only between '0' and the first CR.
//   rx "0007",CR -> err_code=1 on the 4th digit; then "9",LF gives value=9.
//   rx "12" then rst pulse mid-line, then "5",CR -> value=5, no error.
//     busy=0 and all outputs are at reset values immediately on rst.

Source files
------------

// File: rtl/uart_dec_parser.sv
// uart_dec_parser: turns a line of ASCII decimal digits, ended by CR or LF,
// into one binary value pulse. Malformed or out-of-range lines give one error
// pulse and leave the held value untouched.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | between lines, no digit seen yet; CR/LF and spaces are ignored
// S_ACCUM   | at least one digit accumulated, waiting for more or a terminator
// S_DISCARD | line already rejected; swallow bytes until the next terminator
module uart_dec_parser #(
  parameter int WIDTH      = 8,
  parameter int MAX_VALUE  = 255,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             received,
  output logic [WIDTH-1:0] value,
  output logic             value_valid,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy
);

  // Four spare bits keep acc*10 + 9 from wrapping before the range compare.
  localparam int AW = WIDTH + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_BAD_CHAR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [AW-1:0]    r_acc;
  logic [AW-1:0]    w_acc_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_value_nxt;
  logic             r_value_valid;
  logic             w_value_valid_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic [1:0]       r_err_code;
  logic [1:0]       w_err_code_nxt;

  logic             w_is_digit;
  logic             w_is_term;
  logic             w_is_space;
  logic [AW-1:0]    w_digit;
  logic [AW-1:0]    w_next;
  logic             w_overflow;

  assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign w_is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign w_is_space = (rx_data == 8'h20);

  // For 0x30-0x39 the low nibble is exactly the digit value.
  assign w_digit    = {{(AW-4){1'b0}}, rx_data[3:0]};
  assign w_next     = (r_acc << 3) + (r_acc << 1) + w_digit;
  assign w_overflow = (r_count == CW'(MAX_DIGITS)) || (w_next > AW'(MAX_VALUE));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; only bytes with a received strobe move the FSM.
  always_comb begin
    w_state_nxt = r_state;
    if (received) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_digit)                    w_state_nxt = S_ACCUM;
          else if (!w_is_term && !w_is_space) w_state_nxt = S_DISCARD;
        end
        S_ACCUM: begin
          if (w_is_digit) begin
            if (w_overflow) w_state_nxt = S_DISCARD;
          end else if (w_is_term) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (w_is_term) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output and datapath decode: next accumulator, count, value and pulses.
  always_comb begin
    w_acc_nxt         = r_acc;
    w_count_nxt       = r_count;
    w_value_nxt       = r_value;
    w_value_valid_nxt = 1'b0;
    w_err_nxt         = 1'b0;
    w_err_code_nxt    = r_err_code;
    if (received) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_digit) begin
            w_acc_nxt   = w_digit;
            w_count_nxt = CW'(1);
          end else if (!w_is_term && !w_is_space) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_BAD_CHAR;
          end
        end
        S_ACCUM: begin
          if (w_is_digit) begin
            if (w_overflow) begin
              w_err_nxt      = 1'b1;
              w_err_code_nxt = ERR_OVERFLOW;
            end else begin
              w_acc_nxt   = w_next;
              w_count_nxt = r_count + CW'(1);
            end
          end else if (w_is_term) begin
            w_value_nxt       = r_acc[WIDTH-1:0];
            w_value_valid_nxt = 1'b1;
            w_acc_nxt         = '0;
            w_count_nxt       = '0;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_BAD_CHAR;
          end
        end
        S_DISCARD: begin
          if (w_is_term) begin
            w_acc_nxt   = '0;
            w_count_nxt = '0;
          end
        end
        default: begin
          w_acc_nxt   = '0;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // Datapath and output registers; pulses land on the consuming edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc         <= '0;
      r_count       <= '0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 2'd0;
    end else begin
      r_acc         <= w_acc_nxt;
      r_count       <= w_count_nxt;
      r_value       <= w_value_nxt;
      r_value_valid <= w_value_valid_nxt;
      r_err         <= w_err_nxt;
      r_err_code    <= w_err_code_nxt;
    end
  end

  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_dec_parser.sv
// Bench for uart_dec_parser: directed lines plus random byte streams, with a
// line-level reference model feeding an expected-event queue and a monitor
// that checks every pulse the DUT produces.
module tb_uart_dec_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       received = 1'b0;
  logic [7:0] value;
  logic       value_valid;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];

  // Reference model: the line seen so far, in plain integers.
  bit m_in_line = 0;
  bit m_bad     = 0;
  int m_ndig    = 0;
  int m_val     = 0;
  logic [7:0] mon_last = 8'h00;

  uart_dec_parser #(.WIDTH(8), .MAX_VALUE(255), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .received(received),
    .value(value), .value_valid(value_valid), .err(err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit is_err, input int data);
    exp_t e;
    e.is_err = is_err;
    e.data   = 8'(data);
    q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit is_digit, is_term, is_space;
    int d;
    is_digit = (b >= "0") && (b <= "9");
    is_term  = (b == 8'h0D) || (b == 8'h0A);
    is_space = (b == 8'h20);
    d = int'(b) - 48;
    if (m_bad) begin
      if (is_term) begin m_bad = 0; m_in_line = 0; end
    end else if (is_digit) begin
      if (!m_in_line) begin
        m_in_line = 1; m_ndig = 1; m_val = d;
      end else if (m_ndig >= 3 || m_val * 10 + d > 255) begin
        push_exp(1, 1); m_bad = 1; m_in_line = 0;
      end else begin
        m_val = m_val * 10 + d; m_ndig++;
      end
    end else if (is_term) begin
      if (m_in_line) begin push_exp(0, m_val); m_in_line = 0; end
    end else if (is_space && !m_in_line) begin
      // leading space between lines is ignored
    end else begin
      push_exp(1, 2); m_bad = 1; m_in_line = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    received = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1;
    received = 1'b0;
    rx_data  = 8'h00;
    chk("busy", int'(busy), int'(m_in_line || m_bad));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    idle(2);
    rst = 1'b1;
    #1;
    chk("rst_value", int'(value), 0);
    chk("rst_value_valid", int'(value_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_busy", int'(busy), 0);
    m_in_line = 0; m_bad = 0; m_ndig = 0; m_val = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      mon_last <= 8'h00;
    end else begin
      if (value_valid && err) begin
        errors++;
        checks++;
        $display("FAIL both_pulses: value_valid=%0d err=%0d required not both", value_valid, err);
      end
      if (value_valid || err) begin
        if (q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_pulse: value_valid=%0d err=%0d value=%0d code=%0d, none expected",
                   value_valid, err, value, err_code);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind_is_err", int'(err), int'(e.is_err));
          if (e.is_err) chk("err_code", int'(err_code), int'(e.data[1:0]));
          else begin
            chk("value", int'(value), int'(e.data));
            mon_last <= e.data;
          end
        end
      end else begin
        chk("value_hold", int'(value), int'(mon_last));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;
    #1;
    chk("init_busy", int'(busy), 0);
    chk("init_value", int'(value), 0);
    idle(2);
    rst = 1'b0;
    idle(2);

    send_str("123"); send(8'h0D); idle(3);
    send_str("255"); send(8'h0A); send_str("256"); send(8'h0A); idle(3);
    send_str("4x2"); send(8'h0D); idle(3);
    send(8'h0D); send(8'h0A); send(8'h0D); send(8'h0A);
    send_str("0"); send(8'h0D); send(8'h0A); idle(3);
    send_str("0007"); send(8'h0D); send_str("9"); send(8'h0A); idle(3);
    send_str("000"); send(8'h0A); idle(2);
    send_str(" 42"); send(8'h0A); send_str("4 2"); send(8'h0A); idle(3);
    send_str("7"); send(8'h0A); idle(3);
    send_str("12");
    do_reset();
    send_str("5"); send(8'h0D); idle(3);

    // Random well-formed-ish numbers, some with leading zeros.
    for (int k = 0; k < 60; k++) begin
      int n;
      n = $urandom_range(0, 299);
      if ($urandom_range(0, 3) == 0) send("0");
      send_str($sformatf("%0d", n));
      send($urandom_range(0, 1) ? 8'h0A : 8'h0D);
      idle($urandom_range(0, 2));
    end

    // Random byte soup.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'(48 + $urandom_range(0, 9));
      else if (r < 75) b = $urandom_range(0, 1) ? 8'h0A : 8'h0D;
      else if (r < 82) b = 8'h20;
      else begin
        b = 8'(65 + $urandom_range(0, 57));
      end
      send(b);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    send(8'h0A);

    idle(4);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
